countdown_timer: RTL and testbench

- Loadable down-counter with a small control FSM. It is the count-down complement of the team's 4-bit enable/reset up-counter.
- It is loaded with a start value, decrements on each enabled clock, and signals expiry with a one-cycle `done` pulse.
- It sits beside the up-counter in the recitation counter set and serves as a timeout/interval timer for control logic.

---
 rtl/countdown_pkg.sv | 13 +
 rtl/countdown_core.sv | 32 +++
 rtl/countdown_timer.sv | 145 ++++++++++++++
 tb/tb_countdown_timer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/countdown_pkg.sv
// Shared definitions for the countdown timer: state encoding and default width.
package countdown_pkg;

   localparam int DEFAULT_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/countdown_core.sv
// WIDTH-bit count register with clear/load/decrement controls and a zero flag.
module countdown_core
   import countdown_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] value,
   input  logic             dec,
   output logic [WIDTH-1:0] count,
   output logic             zero
);

   assign zero = (count == '0);

   // Decrement saturates at zero so the count can never wrap to all-ones.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (load) begin
         count <= value;
      end else if (dec && !zero) begin
         count <= count - WIDTH'(1);
      end
   end

endmodule

// File: rtl/countdown_timer.sv
// Loadable countdown timer with one-cycle done pulse; macro COUNTDOWN_AUTO_RELOAD_EN
// enables automatic reload from the last accepted load value on expiry.
//
// state | meaning
// IDLE  | ready for load, count held
// RUN   | decrementing while enable is high
// HOLD  | paused, count frozen until enable returns
// DONE  | one-cycle expiry, count is zero, done high
module countdown_timer
   import countdown_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             enable,
   input  logic             abort,
   output logic [WIDTH-1:0] count,
   output logic             ready,
   output logic             busy,
   output logic             done
);

   state_t           state;
   logic             core_clear;
   logic             core_load;
   logic             core_dec;
   logic [WIDTH-1:0] core_value;
   logic             zero;
   logic             reload_go;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
   logic [WIDTH-1:0] reload;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         reload <= '0;
      end else if (state == IDLE && load) begin
         reload <= load_value;
      end else if ((state == RUN || state == HOLD) && abort) begin
         reload <= '0;
      end
   end

   assign reload_go = (reload != '0);
`else
   assign reload_go = 1'b0;
`endif

   always_comb begin
      core_clear = 1'b0;
      core_load  = 1'b0;
      core_dec   = 1'b0;
      core_value = load_value;
      case (state)
         IDLE: core_load = load;
         RUN: begin
            core_clear = abort;
            core_dec   = enable && !abort;
         end
         HOLD: core_clear = abort;
         DONE: begin
            core_load = reload_go;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            core_value = reload;
`endif
         end
         default: ;
      endcase
   end

   countdown_core #(.WIDTH(WIDTH)) u_core (
      .clock (clock),
      .reset (reset),
      .clear (core_clear),
      .load  (core_load),
      .value (core_value),
      .dec   (core_dec),
      .count (count),
      .zero  (zero)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         ready <= 1'b1;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (load) begin
                  ready <= 1'b0;
                  if (load_value == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= RUN;
                     busy  <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (abort) begin
                  state <= IDLE;
                  ready <= 1'b1;
                  busy  <= 1'b0;
               end else if (enable) begin
                  // zero is a guard only: a running count is never zero
                  if (count == WIDTH'(1) || zero) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end else begin
                  state <= HOLD;
               end
            end
            HOLD: begin
               if (abort) begin
                  state <= IDLE;
                  ready <= 1'b1;
                  busy  <= 1'b0;
               end else if (enable) begin
                  state <= RUN;
               end
            end
            DONE: begin
               if (reload_go) begin
                  state <= RUN;
                  busy  <= 1'b1;
               end else begin
                  state <= IDLE;
                  ready <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: randomized and directed stimulus against a reference model.
module tb_countdown_timer;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       load = 1'b0;
   logic [3:0] load_value = 4'd0;
   logic       enable = 1'b0;
   logic       abort = 1'b0;
   logic [3:0] count;
   logic       ready;
   logic       busy;
   logic       done;

   typedef struct {
      int c;
      bit r;
      bit b;
      bit d;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   failures = 0;

   // reference model state
   int m_count = 0;
   int m_reload = 0;
   bit m_active = 0;
   bit m_paused = 0;
   bit m_expired = 0;

   countdown_timer #(.WIDTH(4)) dut (
      .clock      (clock),
      .reset      (reset),
      .load       (load),
      .load_value (load_value),
      .enable     (enable),
      .abort      (abort),
      .count      (count),
      .ready      (ready),
      .busy       (busy),
      .done       (done)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // monitor: compares DUT outputs once per cycle against the oldest expectation
   initial begin
      exp_t e;
      forever begin
         @(posedge clock);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            check("count", int'(count), e.c);
            check("ready", int'(ready), int'(e.r));
            check("busy", int'(busy), int'(e.b));
            check("done", int'(done), int'(e.d));
         end
      end
   end

   task automatic step(input bit ld, input int lv, input bit en, input bit ab);
      exp_t e;
      @(posedge clock);
      #2;
      load       = ld;
      load_value = 4'(lv);
      enable     = en;
      abort      = ab;
      if (m_expired) begin
         m_expired = 0;
         if (AUTO && m_reload != 0) begin
            m_count  = m_reload;
            m_active = 1;
            m_paused = 0;
         end
      end else if (!m_active) begin
         if (ld) begin
            m_count  = lv;
            m_reload = lv;
            if (lv == 0) m_expired = 1;
            else begin
               m_active = 1;
               m_paused = 0;
            end
         end
      end else if (ab) begin
         m_active = 0;
         m_count  = 0;
         m_reload = 0;
      end else if (!en) begin
         m_paused = 1;
      end else if (m_paused) begin
         m_paused = 0;
      end else begin
         m_count = m_count - 1;
         if (m_count == 0) begin
            m_active  = 0;
            m_expired = 1;
         end
      end
      e.c = m_count;
      e.r = !m_active && !m_expired;
      e.b = m_active;
      e.d = m_expired;
      q.push_back(e);
   endtask

   task automatic settle();
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      step(0, 0, 0, 0);
   endtask

   initial begin
      @(posedge clock);
      #1;
      check("reset_count", int'(count), 0);
      check("reset_ready", int'(ready), 1);
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
      #1 reset = 1'b0;

      // basic countdown from 5
      step(1, 5, 1, 0);
      for (int i = 0; i < 7; i++) step(0, 0, 1, 0);
      settle();

      // zero load
      step(1, 0, 1, 0);
      step(0, 0, 1, 0);
      step(0, 0, 1, 0);
      settle();

      // pause at 4 for three cycles, then resume
      step(1, 6, 1, 0);
      step(0, 0, 1, 0);
      step(0, 0, 1, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
      for (int i = 0; i < 7; i++) step(0, 0, 1, 0);
      settle();

      // abort at 5, with a load attempted while busy
      step(1, 9, 1, 0);
      step(1, 2, 1, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
      step(0, 0, 1, 1);
      step(0, 0, 1, 0);
      step(0, 0, 1, 0);

      // reload train, then abort
      step(1, 3, 1, 0);
      for (int i = 0; i < 10; i++) step(1, 7, 1, 0);
      settle();

      // async reset between edges at count 3; inputs during reset are ignored
      step(1, 9, 1, 0);
      for (int i = 0; i < 20 && m_count != 3; i++) step(0, 0, 1, 0);
      @(posedge clock);
      #2;
      reset      = 1'b1;
      load       = 1'b1;
      load_value = 4'd7;
      enable     = 1'b1;
      #1;
      check("async_count", int'(count), 0);
      check("async_ready", int'(ready), 1);
      check("async_busy", int'(busy), 0);
      check("async_done", int'(done), 0);
      @(posedge clock);
      #1;
      check("held_count", int'(count), 0);
      check("held_ready", int'(ready), 1);
      #1;
      reset     = 1'b0;
      load      = 1'b0;
      m_count   = 0;
      m_reload  = 0;
      m_active  = 0;
      m_paused  = 0;
      m_expired = 0;
      step(0, 0, 1, 0);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         step(($urandom % 4) == 0, int'($urandom % 16), ($urandom % 5) != 0,
              ($urandom % 20) == 0);
      end

      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clock);
      #3;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
